// File: rtl/test_result_monitor.sv
// Watches the core commit stream and latches a pass/fail verdict on the halt trap.
// Forced fail on illegal commits, misaligned PCs, run timeout or commit stall.
//
// state  | meaning
// RUN    | test executing, counters live
// PASS   | halt trap seen with a0 == PASS_VALUE (sticky until reset)
// FAIL   | bad halt, illegal/misaligned commit, timeout or stall (sticky)
module test_result_monitor #(
  parameter logic [31:0] HALT_INSTR     = 32'h0005006b,
  parameter logic [63:0] PASS_VALUE     = 64'd0,
  parameter logic [63:0] TIMEOUT_CYCLES = 64'd1_000_000,
  parameter logic [63:0] STALL_LIMIT    = 64'd4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        commit_valid,
  input  logic [63:0] commit_pc,
  input  logic [31:0] commit_instr,
  input  logic        commit_illegal,
  input  logic [63:0] commit_a0,
  output logic [1:0]  result,
  output logic        halted,
  output logic [63:0] cycle_count,
  output logic [63:0] instr_count
);

  // State encodings double as the result code, so result is the state register.
  localparam logic [1:0] S_RUN  = 2'b00;
  localparam logic [1:0] S_PASS = 2'b10;
  localparam logic [1:0] S_FAIL = 2'b01;

  localparam logic [63:0] STALL_TC   = STALL_LIMIT - 64'd1;
  localparam logic [63:0] TIMEOUT_TC = TIMEOUT_CYCLES - 64'd1;
  localparam logic [63:0] CNT_MAX    = '1;

  logic [1:0]  state_q, state_d;
  logic [63:0] cycle_q, cycle_d;
  logic [63:0] instr_q, instr_d;
  logic [63:0] stall_q, stall_d;

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    instr_d = instr_q;
    stall_d = stall_q;
    if (state_q == S_RUN) begin
      if (cycle_q != CNT_MAX) cycle_d = cycle_q + 64'd1;
      if (commit_valid) begin
        stall_d = '0;
        if (instr_q != CNT_MAX) instr_d = instr_q + 64'd1;
      end else if (stall_q != CNT_MAX) begin
        stall_d = stall_q + 64'd1;
      end

      // Priority order: a halt commit beats stall and timeout expiry.
      if (commit_valid && commit_illegal) begin
        state_d = S_FAIL;
      end else if (commit_valid && (commit_pc[1:0] != 2'b00)) begin
        state_d = S_FAIL;
      end else if (commit_valid && (commit_instr == HALT_INSTR)) begin
        state_d = (commit_a0 == PASS_VALUE) ? S_PASS : S_FAIL;
      end else if (!commit_valid && (stall_q == STALL_TC)) begin
        state_d = S_FAIL;
      end else if (cycle_q == TIMEOUT_TC) begin
        state_d = S_FAIL;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      cycle_q <= '0;
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      instr_q <= instr_d;
      stall_q <= stall_d;
    end
  end

  assign result      = state_q;
  assign halted      = (state_q != S_RUN);
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;

endmodule

// File: doc/test_result_monitor.md
# test_result_monitor

Sits inside `Top` between the core's commit stage and the top-level `result[1:0]` port. It watches the commit stream and detects the halt-trap instruction. On halt it checks register a0 and latches pass or fail. A cycle timeout and a no-commit stall watchdog also force fail, so a hung core cannot leave the testbench waiting forever.

## Interface
- `HALT_INSTR`, 32'h0005006b — instruction encoding treated as test-end trap
- `PASS_VALUE`, 64'd0 — a0 value at halt that means pass
- `TIMEOUT_CYCLES`, 1_000_000 — max cycles in RUN before forced fail
- `STALL_LIMIT`, 4096 — max consecutive cycles without a commit before forced fail
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = in reset)
- `commit_valid`  in  1  one instruction retires this cycle
- `commit_pc`  in  64  PC of retiring instruction
- `commit_instr`  in  32  encoding of retiring instruction
- `commit_illegal`  in  1  retiring instruction raised illegal-instruction; qualified by `commit_valid`
- `commit_a0`  in  64  architectural x10 value as seen by the retiring instruction
- `result`  out  2  2'b00 running, 2'b10 pass, 2'b01 fail; 2'b11 never driven
- `halted`  out  1  high once in PASS or FAIL
- `cycle_count`  out  64  cycles spent in RUN
- `instr_count`  out  64  commits observed in RUN, including the halt instruction

## Operation
- States: RUN, PASS, FAIL. PASS and FAIL are terminal and sticky until reset.
- `result` and `halted` are registered and decoded from state: RUN gives 00/0, PASS gives 10/1, FAIL gives 01/1.
- In RUN, evaluate one condition per cycle, first match wins:
  1. `commit_valid && commit_illegal` → FAIL.
  2. `commit_valid && commit_pc[1:0] != 0` → FAIL (misaligned PC).
  3. `commit_valid && commit_instr == HALT_INSTR`: a0 == `PASS_VALUE` → PASS, otherwise FAIL.
  4. Stall counter == `STALL_LIMIT-1` and `!commit_valid` → FAIL.
  5. `cycle_count == TIMEOUT_CYCLES-1` → FAIL.
  6. Otherwise stay in RUN.
- A halt commit in the same cycle as timeout or stall expiry resolves per the halt check (rule 3 beats rules 4 and 5).
- `cycle_count` increments by 1 every RUN cycle. It saturates at all-ones and freezes on leaving RUN.
- `instr_count` increments on each `commit_valid` in RUN, including the terminating commit. It saturates and freezes the same way.
- Stall counter (internal, 64-bit, saturating): cleared on any `commit_valid`, incremented otherwise, only in RUN.
- `commit_*` inputs are ignored in PASS/FAIL, and the counters hold.
- All comparisons are unsigned and full-width. `commit_a0` is compared against all 64 bits of `PASS_VALUE`.

## Timing
- Reset asserted (`reset`=0) asynchronously forces: state RUN, `result`=00, `halted`=0, `cycle_count`=0, `instr_count`=0, stall counter = 0.
- First RUN cycle is the first rising edge with `reset`=1. `cycle_count` reads 1 after that edge.
- Latency: a terminating condition sampled at edge N makes `result` and `halted` valid after edge N. The testbench sees them one cycle after the commit.
- Reset asserted mid-run or in a terminal state returns to RUN immediately, without waiting for a clock edge. Counters clear.
- No handshake back-pressure: the monitor never stalls the core. `commit_valid` may be high every cycle.

## Test plan
- Reset low 2 cycles, release, commit 5 ordinary instructions (pc 0x80000000 step 4), then HALT_INSTR with a0=0 → `result`=10 and `halted`=1 one cycle after the halt commit; `instr_count`=6.
- Same sequence, a0=64'h1 at halt → `result`=01; further commits do not change `result` or `instr_count`.
- TIMEOUT_CYCLES=100, STALL_LIMIT=1000, commit every cycle, no halt → `result`=01 after edge 100; `cycle_count`=100.
- STALL_LIMIT=16, one commit, then idle → `result`=01 exactly 16 idle edges later; a commit on idle cycle 15 instead resets the count and keeps RUN.
- Halt commit with a0=0 on the timeout cycle → `result`=10. Commit with pc=0x80000002 → `result`=01. Commit with `commit_illegal`=1 → `result`=01.
- Drive to PASS, pulse `reset` low between edges → `result`=00 and counters 0 immediately; a new run then passes normally.
